// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - opcode/state enums and op-class helpers for mem_access_unit
package mem_pkg;

    typedef enum logic [3:0] {
        OP_LB  = 4'd0,
        OP_LBU = 4'd1,
        OP_LH  = 4'd2,
        OP_LHU = 4'd3,
        OP_LW  = 4'd4,
        OP_LWL = 4'd5,
        OP_LWR = 4'd6,
        OP_SB  = 4'd7,
        OP_SH  = 4'd8,
        OP_SW  = 4'd9,
        OP_SWL = 4'd10,
        OP_SWR = 4'd11
    } mem_op_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_REQ = 3'd1,
        ST_RD_CAP = 3'd2,
        ST_WR_REQ = 3'd3,
        ST_RESP   = 3'd4
    } mac_state_t;

    // Big-endian: lane 0 lives in bits [31:24], so lane n sits 8*(3-n) bits up.
    function automatic logic [4:0] lane_shift(input logic [1:0] lane);
        return {~lane, 3'b000};
    endfunction

    function automatic logic is_load(input mem_op_t op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR};
    endfunction

    function automatic logic is_signed(input mem_op_t op);
        return op inside {OP_LB, OP_LH};
    endfunction

    function automatic logic needs_rmw(input mem_op_t op);
        return op inside {OP_SB, OP_SH, OP_SWL, OP_SWR};
    endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// rtl/byte_lane_merge.sv - combinational load lane extract/extend and store lane merge
module byte_lane_merge (
    input  logic [3:0]  op,
    input  logic [1:0]  offset,
    input  logic [31:0] mem_word,
    input  logic [31:0] rt_old,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);
    import mem_pkg::*;

    mem_op_t    op_e;
    logic [4:0] bshift;
    logic [4:0] hshift;
    logic [4:0] lshift;
    logic [7:0] byte_sel;
    logic [15:0] half_sel;

    assign op_e   = mem_op_t'(op);
    assign bshift = lane_shift(offset);
    // Halfwords only look at offset[1]; offset[0] is either trapped or ignored upstream.
    assign hshift = {~offset[1], 4'b0000};
    assign lshift = {offset, 3'b000};

    always_comb begin
        byte_sel   = 8'(mem_word >> bshift);
        half_sel   = 16'(mem_word >> hshift);
        load_data  = mem_word;
        store_data = mem_word;
        case (op_e)
            OP_LB, OP_LBU: load_data = {{24{is_signed(op_e) & byte_sel[7]}}, byte_sel};
            OP_LH, OP_LHU: load_data = {{16{is_signed(op_e) & half_sel[15]}}, half_sel};
            OP_LW:         load_data = mem_word;
            OP_LWL:        load_data = (mem_word << lshift) | (rt_old & ~(32'hFFFF_FFFF << lshift));
            OP_LWR:        load_data = (mem_word >> bshift) | (rt_old & ~(32'hFFFF_FFFF >> bshift));
            OP_SB:         store_data = (mem_word & ~(32'h0000_00FF << bshift))
                                      | ({24'b0, wdata[7:0]} << bshift);
            OP_SH:         store_data = (mem_word & ~(32'h0000_FFFF << hshift))
                                      | ({16'b0, wdata[15:0]} << hshift);
            OP_SW:         store_data = wdata;
            OP_SWL:        store_data = (mem_word & ~(32'hFFFF_FFFF >> lshift)) | (wdata >> lshift);
            OP_SWR:        store_data = (mem_word & ~(32'hFFFF_FFFF << bshift)) | (wdata << bshift);
            default:       ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MIPS load/store to word-access sequencer with RMW; ALIGN_CHECK_EN enables misalignment trap
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [DATA_W-1:0] req_rt_old,
    output logic              stall,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              addr_error,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_read_addr,
    output logic [ADDR_W-1:0] mem_write_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic              mem_wait,
    input  logic [DATA_W-1:0] mem_read_data
);

    mac_state_t        state_q;
    mac_state_t        state_d;
    mem_op_t           req_op_e;
    mem_op_t           op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rt_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              accept;
    logic              misalign;
    logic [31:0]       load_data;
    logic [31:0]       store_data;

    assign req_op_e = mem_op_t'(req_op);

`ifdef ALIGN_CHECK_EN
    always_comb begin
        misalign = 1'b0;
        case (req_op_e)
            OP_LH, OP_LHU, OP_SH: misalign = req_addr[0];
            OP_LW, OP_SW:         misalign = |req_addr[1:0];
            default:              misalign = 1'b0;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    byte_lane_merge u_merge (
        .op         (op_q),
        .offset     (addr_q[1:0]),
        .mem_word   (mem_read_data),
        .rt_old     (rt_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    always_comb begin
        state_d    = state_q;
        stall      = 1'b0;
        resp_valid = 1'b0;
        mem_wr_en  = 1'b0;
        accept     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stall = req_valid;
                if (req_valid) begin
                    accept = 1'b1;
                    if (misalign)
                        state_d = ST_RESP;
                    else if (is_load(req_op_e) || needs_rmw(req_op_e))
                        state_d = ST_RD_REQ;
                    else if (req_op_e == OP_SW)
                        state_d = ST_WR_REQ;
                    else
                        state_d = ST_RESP;  // undefined opcode completes as a no-op
                end
            end
            ST_RD_REQ: begin
                stall = 1'b1;
                if (!mem_wait)
                    state_d = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                stall   = 1'b1;
                state_d = is_load(op_q) ? ST_RESP : ST_WR_REQ;
            end
            ST_WR_REQ: begin
                stall     = 1'b1;
                mem_wr_en = 1'b1;
                if (!mem_wait)
                    state_d = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LB;
            addr_q  <= '0;
            wdata_q <= '0;
            rt_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= req_op_e;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rt_q    <= req_rt_old;
                rdata_q <= '0;
                err_q   <= misalign;
            end
            // wdata_q doubles as the merged write word once the old word is in hand.
            if (state_q == ST_RD_CAP) begin
                if (is_load(op_q))
                    rdata_q <= load_data;
                else
                    wdata_q <= store_data;
            end
        end
    end

    assign resp_rdata     = rdata_q;
    assign addr_error     = resp_valid & err_q;
    assign mem_read_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_write_addr = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_write_data = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit with directed load/store vectors
module tb_mem_access_unit;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [3:0]  req_op = 4'd0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [31:0] req_rt_old = '0;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        addr_error;
    logic        mem_wr_en;
    logic [31:0] mem_read_addr;
    logic [31:0] mem_write_addr;
    logic [31:0] mem_write_data;
    logic        mem_wait = 1'b0;
    logic [31:0] mem_read_data;

    logic [31:0] mem_model [0:1023];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          start;
        int          lat;
    } resp_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_exp_t;

    resp_exp_t resp_q[$];
    wr_exp_t   wr_q[$];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int wr_cycles = 0;

    mem_access_unit dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_rt_old     (req_rt_old),
        .stall          (stall),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .addr_error     (addr_error),
        .mem_wr_en      (mem_wr_en),
        .mem_read_addr  (mem_read_addr),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data),
        .mem_wait       (mem_wait),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mem_read_data = (mem_read_addr[1:0] == 2'b00) ? mem_model[mem_read_addr[11:2]] : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && resp_valid) begin
            chk("resp_expected", resp_q.size() != 0, 1);
            if (resp_q.size() != 0) begin
                resp_exp_t e;
                e = resp_q.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("addr_error", addr_error, e.err);
                chk("resp_stall_low", stall, 0);
                if (e.lat >= 0)
                    chk("resp_latency", cyc - e.start, e.lat);
            end
        end
    end

    always @(negedge clk) begin
        if (mem_wr_en)
            wr_cycles++;
        if (!reset && mem_wr_en && !mem_wait) begin
            chk("write_expected", wr_q.size() != 0, 1);
            if (wr_q.size() != 0) begin
                wr_exp_t w;
                w = wr_q.pop_front();
                chk("write_addr", mem_write_addr, w.addr);
                chk("write_data", mem_write_data, w.data);
                mem_model[mem_write_addr[11:2]] = mem_write_data;
            end
        end
    end

    task automatic do_req(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rt, input int nwait, input logic [31:0] exp_rdata,
                          input logic exp_err, input int exp_lat, input logic exp_wr,
                          input logic [31:0] exp_waddr, input logic [31:0] exp_wdata,
                          input int exp_wr_cycles);
        int c;
        int w0;
        logic done;
        resp_exp_t e;
        wr_exp_t w;
        @(posedge clk); #1;
        req_valid  = 1'b1;
        req_op     = op;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rt_old = rt;
        mem_wait   = 1'b0;
        w0 = wr_cycles;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.start = cyc;
        e.lat   = exp_lat;
        resp_q.push_back(e);
        if (exp_wr) begin
            w.addr = exp_waddr;
            w.data = exp_wdata;
            wr_q.push_back(w);
        end
        c = 0;
        done = 1'b0;
        while (!done && c < 40) begin
            @(negedge clk);
            if (resp_valid) done = 1'b1;
            else chk("stall_busy", stall, 1);
            @(posedge clk); #1;
            c++;
            if (done) begin
                req_valid = 1'b0;
                mem_wait  = 1'b0;
            end else begin
                mem_wait = (c <= nwait);
            end
        end
        chk("resp_seen", done, 1);
        chk("wr_en_cycles", wr_cycles - w0, exp_wr_cycles);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem_model[i] = '0;
        mem_model[32'h100 >> 2] = 32'h1122_33F4;
        mem_model[32'h140 >> 2] = 32'h8899_AABB;
        mem_model[32'h180 >> 2] = 32'h1122_3344;
        mem_model[32'h300 >> 2] = 32'hAABB_CCDD;
        mem_model[32'h400 >> 2] = 32'h0102_0304;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", stall, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_addr_error", addr_error, 0);
        chk("rst_wr_en", mem_wr_en, 0);
        chk("rst_read_addr", mem_read_addr, 0);
        chk("rst_write_addr", mem_write_addr, 0);
        chk("rst_write_data", mem_write_data, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // op, addr, wdata, rt, nwait, rdata, err, lat, wr, waddr, wdata, wr_cycles
        do_req(OP_LB,  32'h103, 32'h0,         32'h0,         0, 32'hFFFF_FFF4, 0, 3, 0, 0, 0, 0);
        do_req(OP_LBU, 32'h103, 32'h0,         32'h0,         0, 32'h0000_00F4, 0, 3, 0, 0, 0, 0);
        do_req(OP_LH,  32'h140, 32'h0,         32'h0,         0, 32'hFFFF_8899, 0, 3, 0, 0, 0, 0);
        do_req(OP_LHU, 32'h142, 32'h0,         32'h0,         0, 32'h0000_AABB, 0, 3, 0, 0, 0, 0);
        do_req(OP_LW,  32'h140, 32'h0,         32'h0,         2, 32'h8899_AABB, 0, 5, 0, 0, 0, 0);
        do_req(OP_LWL, 32'h301, 32'h0,         32'h1122_3344, 0, 32'hBBCC_DD44, 0, 3, 0, 0, 0, 0);
        do_req(OP_LWR, 32'h301, 32'h0,         32'h1122_3344, 0, 32'h1122_AABB, 0, 3, 0, 0, 0, 0);
        do_req(OP_SB,  32'h181, 32'hFFFF_FFAB, 32'h0,         0, 32'h0,         0, 4, 1, 32'h180, 32'h11AB_3344, 1);
        do_req(OP_LW,  32'h180, 32'h0,         32'h0,         0, 32'h11AB_3344, 0, 3, 0, 0, 0, 0);
        do_req(OP_SH,  32'h182, 32'h1234_CAFE, 32'h0,         0, 32'h0,         0, 4, 1, 32'h180, 32'h11AB_CAFE, 1);
        do_req(OP_SW,  32'h200, 32'hDEAD_BEEF, 32'h0,         5, 32'h0,         0, -1, 1, 32'h200, 32'hDEAD_BEEF, 6);
        do_req(OP_SWL, 32'h302, 32'hCAFE_F00D, 32'h0,         0, 32'h0,         0, 4, 1, 32'h300, 32'hAABB_CAFE, 1);
        do_req(OP_SWR, 32'h302, 32'h1122_3344, 32'h0,         0, 32'h0,         0, 4, 1, 32'h300, 32'h2233_44FE, 1);
`ifdef ALIGN_CHECK_EN
        do_req(OP_LW,  32'h402, 32'h0,         32'h0,         0, 32'h0,         1, 1, 0, 0, 0, 0);
        do_req(OP_SH,  32'h181, 32'h0000_5555, 32'h0,         0, 32'h0,         1, 1, 0, 0, 0, 0);
        do_req(OP_LH,  32'h140, 32'h0,         32'h0,         0, 32'hFFFF_8899, 0, 3, 0, 0, 0, 0);
`else
        do_req(OP_LW,  32'h402, 32'h0,         32'h0,         0, 32'h0102_0304, 0, 3, 0, 0, 0, 0);
        do_req(OP_LH,  32'h141, 32'h0,         32'h0,         0, 32'hFFFF_8899, 0, 3, 0, 0, 0, 0);
`endif

        // Abort a store stuck in WR_REQ with a mid-operation reset.
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = OP_SW;
        req_addr  = 32'h500;
        req_wdata = 32'h5555_AAAA;
        mem_wait  = 1'b0;
        @(posedge clk); #1;
        mem_wait = 1'b1;
        @(negedge clk);
        chk("abort_pre_wr_en", mem_wr_en, 1);
        @(posedge clk); #1;
        reset     = 1'b1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset    = 1'b0;
        mem_wait = 1'b0;
        @(negedge clk);
        chk("abort_wr_en", mem_wr_en, 0);
        chk("abort_stall", stall, 0);
        chk("abort_resp_valid", resp_valid, 0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_resp", resp_valid, 0);
        end

        do_req(OP_LW,  32'h200, 32'h0,         32'h0,         0, 32'hDEAD_BEEF, 0, 3, 0, 0, 0, 0);
        do_req(OP_LW,  32'h500, 32'h0,         32'h0,         0, 32'h0,         0, 3, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        chk("resp_queue_empty", resp_q.size(), 0);
        chk("write_queue_empty", wr_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
